reg_bank: RTL

Parametrised general-purpose register bank for the 16-bit datapath: N registers of DATA_W bits, two combinational read ports, and one write port with its own address. Unlike the previous bank, it has a hardwired zero register and optional write-to-read bypass. It also has a dedicated stack-pointer register with push/pop counting and sticky bounds checking. It sits between instruction decode and the ALU; the control FSM drives write enable and stack operations.

---
 rtl/reg_bank_pkg.sv | 11 +
 rtl/reg_bank_if.sv | 30 +++
 rtl/reg_bank_sp_ctrl.sv | 72 +++++++
 rtl/reg_bank.sv | 83 ++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// Shared constants for the register bank: stack-op encoding and default stack bounds.
package reg_bank_pkg;

  localparam logic [1:0] SP_NONE = 2'b00;
  localparam logic [1:0] SP_PUSH = 2'b01;
  localparam logic [1:0] SP_POP  = 2'b10;

  localparam logic [15:0] DEF_SP_TOP    = 16'h07FF;
  localparam logic [15:0] DEF_SP_BOTTOM = 16'h0700;

endpackage

// File: rtl/reg_bank_if.sv
// Register bank bus: two read ports, one write port and stack-pointer control/status.
interface reg_bank_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 5
);

  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [1:0]        sp_op;
  logic [DATA_W-1:0] sp_value;
  logic [DATA_W-1:0] sp_depth;
  logic              sp_err;
  logic              sp_err_clr;

  modport master (
    output rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, sp_op, sp_err_clr,
    input  rd_data_a, rd_data_b, sp_value, sp_depth, sp_err
  );

  modport slave (
    input  rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, sp_op, sp_err_clr,
    output rd_data_a, rd_data_b, sp_value, sp_depth, sp_err
  );

endinterface

// File: rtl/reg_bank_sp_ctrl.sv
// Stack-pointer register with push/pop counting, equality bounds check and sticky error.
module sp_ctrl
  import reg_bank_pkg::*;
#(
  parameter int unsigned         DATA_W    = 16,
  parameter logic [DATA_W-1:0]   SP_TOP    = DEF_SP_TOP,
  parameter logic [DATA_W-1:0]   SP_BOTTOM = DEF_SP_BOTTOM
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_sp_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [1:0]        sp_op_i,
  input  logic              sp_err_clr_i,
  output logic [DATA_W-1:0] sp_value_o,
  output logic [DATA_W-1:0] sp_depth_o,
  output logic              sp_err_o
);

  localparam logic [1:0] StHold = 2'd0;
  localparam logic [1:0] StDec  = 2'd1;
  localparam logic [1:0] StInc  = 2'd2;
  localparam logic [1:0] StLoad = 2'd3;

  localparam logic [DATA_W-1:0] One = {{(DATA_W-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] sp_q, sp_d;
  logic              err_q, err_d;
  logic [1:0]        act;
  logic              err_set;

  always_comb begin
    act     = StHold;
    err_set = 1'b0;
    if (wr_sp_i) begin
      act = StLoad;
    end else if (sp_op_i == SP_PUSH) begin
      if (sp_q == SP_BOTTOM) err_set = 1'b1;
      else                   act     = StDec;
    end else if (sp_op_i == SP_POP) begin
      if (sp_q == SP_TOP) err_set = 1'b1;
      else                act     = StInc;
    end
  end

  always_comb begin
    sp_d = sp_q;
    unique case (act)
      StLoad:  sp_d = wr_data_i;
      StDec:   sp_d = sp_q - One;
      StInc:   sp_d = sp_q + One;
      default: sp_d = sp_q;
    endcase
    // A new error outranks a same-cycle clear.
    err_d = err_set | (err_q & ~sp_err_clr_i);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sp_q  <= SP_TOP;
      err_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      err_q <= err_d;
    end
  end

  assign sp_value_o = sp_q;
  assign sp_depth_o = SP_TOP - sp_q;
  assign sp_err_o   = err_q;

endmodule

// File: rtl/reg_bank.sv
// General-purpose register bank: zero register, two combinational read ports with optional
// write bypass, one write port, and a dedicated stack-pointer register.
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int unsigned       DATA_W    = 16,
  parameter int unsigned       ADDR_W    = 5,
  parameter int unsigned       NUM_REGS  = 16,
  parameter int unsigned       SP_IDX    = 12,
  parameter logic [DATA_W-1:0] SP_TOP    = DEF_SP_TOP,
  parameter logic [DATA_W-1:0] SP_BOTTOM = DEF_SP_BOTTOM,
  parameter bit                BYPASS    = 1'b1
) (
  input logic        clk,
  input logic        reset_n,
  reg_bank_if.slave  bus_io
);

  localparam int unsigned       IdxW     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_W:0]   NumRegsA = NUM_REGS[ADDR_W:0];
  localparam logic [ADDR_W-1:0] SpIdxA   = SP_IDX[ADDR_W-1:0];

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] sp_value;
  logic              wr_valid;
  logic              wr_ok;
  logic [IdxW-1:0]   wr_idx;

  assign wr_valid = ({1'b0, bus_io.wr_addr} < NumRegsA) && (bus_io.wr_addr != '0);
  // SP lives in sp_ctrl, so the array slot at SP_IDX stays zero and unused.
  assign wr_ok    = bus_io.wr_en && wr_valid && (bus_io.wr_addr != SpIdxA);
  assign wr_idx   = bus_io.wr_addr[IdxW-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
    end else if (wr_ok) begin
      regs_q[wr_idx] <= bus_io.wr_data;
    end
  end

  sp_ctrl #(
    .DATA_W    (DATA_W),
    .SP_TOP    (SP_TOP),
    .SP_BOTTOM (SP_BOTTOM)
  ) u_sp_ctrl (
    .clk          (clk),
    .reset_n      (reset_n),
    .wr_sp_i      (bus_io.wr_en && (bus_io.wr_addr == SpIdxA)),
    .wr_data_i    (bus_io.wr_data),
    .sp_op_i      (bus_io.sp_op),
    .sp_err_clr_i (bus_io.sp_err_clr),
    .sp_value_o   (sp_value),
    .sp_depth_o   (bus_io.sp_depth),
    .sp_err_o     (bus_io.sp_err)
  );

  assign bus_io.sp_value = sp_value;

  logic [ADDR_W-1:0] rd_addr [2];
  logic [DATA_W-1:0] rd_data [2];

  assign rd_addr[0]       = bus_io.rd_addr_a;
  assign rd_addr[1]       = bus_io.rd_addr_b;
  assign bus_io.rd_data_a = rd_data[0];
  assign bus_io.rd_data_b = rd_data[1];

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic rd_valid;
    assign rd_valid = ({1'b0, rd_addr[p]} < NumRegsA) && (rd_addr[p] != '0);

    always_comb begin
      rd_data[p] = '0;
      if (BYPASS && bus_io.wr_en && wr_valid && (bus_io.wr_addr == rd_addr[p])) begin
        rd_data[p] = bus_io.wr_data;
      end else if (rd_valid) begin
        if (rd_addr[p] == SpIdxA) rd_data[p] = sp_value;
        else                      rd_data[p] = regs_q[rd_addr[p][IdxW-1:0]];
      end
    end
  end

endmodule
